// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings for the bitwise logic unit and anything that drives it.
package logic_unit_pkg;

    localparam int OP_W = 2;

    localparam logic [OP_W-1:0] OP_AND = 2'd0;
    localparam logic [OP_W-1:0] OP_OR  = 2'd1;
    localparam logic [OP_W-1:0] OP_XOR = 2'd2;
    localparam logic [OP_W-1:0] OP_MUX = 2'd3;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational W-bit bitwise operator: AND / OR / XOR / per-bit select between L and b.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0]    l_i,
    input  logic [W-1:0]    b_i,
    input  logic [W-1:0]    sel_i,
    input  logic [OP_W-1:0] op_i,
    output logic [W-1:0]    r_o
);

    always_comb begin
        r_o = '0;
        case (op_i)
            OP_AND:  r_o = l_i & b_i;
            OP_OR:   r_o = l_i | b_i;
            OP_XOR:  r_o = l_i ^ b_i;
            // sel bit 1 takes b, 0 takes the left operand
            default: r_o = (sel_i & b_i) | (~sel_i & l_i);
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with accumulator, global-stall valid/ready flow control
// and registered zero/parity flags on the output stage.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [W-1:0]    sel,
    input  logic [OP_W-1:0] op,
    input  logic            acc_mode,
    input  logic            acc_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    y,
    output logic            y_zero,
    output logic            y_par,
    output logic [W-1:0]    acc
);

    function automatic logic flag_zero(input logic [W-1:0] v);
        return ~|v;
    endfunction

    function automatic logic flag_par(input logic [W-1:0] v);
        return ^v;
    endfunction

    logic         stall;
    logic         accept;
    logic [W-1:0] left;
    logic [W-1:0] r;
    logic [W-1:0] acc_q, acc_d;
    logic         zero_q, par_q;
    logic [W-1:0] last_d;
    logic         last_v;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    assign left = acc_mode ? (acc_clr ? '0 : acc_q) : a;

    logic_unit_core #(.W(W)) u_core (
        .l_i   (left),
        .b_i   (b),
        .sel_i (sel),
        .op_i  (op),
        .r_o   (r)
    );

    // Accumulator updates on the same edge as the stage-1 load, so chained acc beats see it
    always_comb begin
        acc_d = acc_q;
        if (accept && acc_mode)
            acc_d = r;
        else if (acc_clr)
            acc_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc = acc_q;

    // Stage i loads from stage i-1 (stage 0 from the core); data only moves with a valid beat
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [W-1:0] d_in;
        logic         v_in;
        logic [W-1:0] data_q;
        logic         vld_q;

        if (i == 0) begin : g_head
            assign d_in = r;
            assign v_in = accept;
        end else begin : g_tail
            assign d_in = g_stage[i-1].data_q;
            assign v_in = g_stage[i-1].vld_q;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q  <= 1'b0;
                data_q <= '0;
            end else if (!stall) begin
                vld_q <= v_in;
                if (v_in)
                    data_q <= d_in;
            end
        end
    end

    assign last_d    = g_stage[DEPTH-1].d_in;
    assign last_v    = g_stage[DEPTH-1].v_in;
    assign out_valid = g_stage[DEPTH-1].vld_q;
    assign y         = g_stage[DEPTH-1].data_q;

    // Output stage: flags captured alongside y
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b1;
            par_q  <= 1'b0;
        end else if (!stall && last_v) begin
            zero_q <= flag_zero(last_d);
            par_q  <= flag_par(last_d);
        end
    end

    assign y_zero = zero_q;
    assign y_par  = par_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and model-checked bench for logic_unit_pipe at DEPTH 2 (main), 1 and 4.
module tb_logic_unit_pipe;
    import logic_unit_pkg::*;

    logic       clk = 1'b0;
    logic       rst, in_valid, acc_mode, acc_clr, out_ready;
    logic [7:0] a, b, sel;
    logic [1:0] op;

    logic       in_ready, out_valid, y_zero, y_par;
    logic [7:0] y, acc;
    logic       ir1, ov1, z1, p1;
    logic [7:0] y1, acc1;
    logic       ir4, ov4, z4, p4;
    logic [7:0] y4, acc4;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.W(8), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .y_zero(y_zero),
        .y_par(y_par), .acc(acc)
    );

    logic_unit_pipe #(.W(8), .DEPTH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
        .a(a), .b(b), .sel(sel), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(ov1), .out_ready(1'b1), .y(y1), .y_zero(z1),
        .y_par(p1), .acc(acc1)
    );

    logic_unit_pipe #(.W(8), .DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4),
        .a(a), .b(b), .sel(sel), .op(op), .acc_mode(acc_mode), .acc_clr(acc_clr),
        .out_valid(ov4), .out_ready(1'b1), .y(y4), .y_zero(z4),
        .y_par(p4), .acc(acc4)
    );

    typedef struct {
        logic [1:0] op;
        logic [7:0] a, b, sel, y;
        logic       z, p;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; acc_mode = 1'b0; acc_clr = 1'b0;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] ref_op(input logic [1:0] o, input logic [7:0] l,
                                          input logic [7:0] bb, input logic [7:0] s);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            case (o)
                2'd0: m[i] = l[i] && bb[i];
                2'd1: m[i] = l[i] || bb[i];
                2'd2: m[i] = (l[i] != bb[i]);
                default: m[i] = s[i] ? bb[i] : l[i];
            endcase
        end
        return m;
    endfunction

    vec_t       vt[8];
    logic [7:0] got[8];
    int         ngot, k;
    logic       ir_exp[8];
    logic       ev[80];
    logic [7:0] ey[80];
    logic [7:0] acc_m, lft, rr, last1;

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sel = '0; op = OP_AND;
        acc_mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst y", y, 0);
        chk("rst y_zero", y_zero, 1);
        chk("rst y_par", y_par, 0);
        chk("rst acc", acc, 0);

        // Single-beat ops, latency 2
        vt[0] = '{OP_AND, 8'hF0, 8'h3C, 8'h0F, 8'h30, 1'b0, 1'b0};
        vt[1] = '{OP_OR,  8'hF0, 8'h3C, 8'h0F, 8'hFC, 1'b0, 1'b0};
        vt[2] = '{OP_XOR, 8'hF0, 8'h3C, 8'h0F, 8'hCC, 1'b0, 1'b0};
        vt[3] = '{OP_MUX, 8'hF0, 8'h3C, 8'h0F, 8'hFC, 1'b0, 1'b0};
        vt[4] = '{OP_OR,  8'h01, 8'h00, 8'h00, 8'h01, 1'b0, 1'b1};
        vt[5] = '{OP_MUX, 8'h00, 8'h07, 8'hFF, 8'h07, 1'b0, 1'b1};
        vt[6] = '{OP_XOR, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0};
        vt[7] = '{OP_AND, 8'h00, 8'hFF, 8'hAA, 8'h00, 1'b1, 1'b0};
        for (int i = 0; i < 8; i++) begin
            op = vt[i].op; a = vt[i].a; b = vt[i].b; sel = vt[i].sel;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            op = ~vt[i].op;
            chk($sformatf("vec%0d early valid", i), out_valid, 0);
            step();
            chk($sformatf("vec%0d valid", i), out_valid, 1);
            chk($sformatf("vec%0d y", i), y, vt[i].y);
            chk($sformatf("vec%0d zero", i), y_zero, vt[i].z);
            chk($sformatf("vec%0d par", i), y_par, vt[i].p);
        end
        step();

        // Reset with two beats in flight
        acc_mode = 1'b1; op = OP_OR; b = 8'h22; in_valid = 1'b1;
        step();
        acc_mode = 1'b0; a = 8'h11; b = 8'h22; op = OP_OR;
        step();
        chk("mid y before rst", y, 8'h22);
        chk("mid acc before rst", acc, 8'h22);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst acc", acc, 0);
        chk("mid rst y", y, 0);
        chk("mid rst y_zero", y_zero, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("no stale beat %0d", i), out_valid, 0);
        end

        // Accumulator chaining
        acc_mode = 1'b1; op = OP_OR; in_valid = 1'b1; b = 8'h01;
        step();
        chk("chain acc1", acc, 8'h01);
        b = 8'h02;
        step();
        chk("chain acc2", acc, 8'h03);
        chk("chain y1", y, 8'h01);
        b = 8'h04;
        step();
        chk("chain acc3", acc, 8'h07);
        chk("chain y2", y, 8'h03);
        in_valid = 1'b0;
        step();
        chk("chain y3", y, 8'h07);

        // acc_clr with and without accept
        acc_clr = 1'b1; acc_mode = 1'b1; op = OP_OR; b = 8'h55; in_valid = 1'b1;
        step();
        chk("clr load acc", acc, 8'h55);
        op = OP_XOR; b = 8'hFF;
        step();
        chk("clr xor acc", acc, 8'hFF);
        chk("clr y55", y, 8'h55);
        in_valid = 1'b0; acc_clr = 1'b0;
        step();
        chk("clr yFF", y, 8'hFF);
        chk("clr yFF valid", out_valid, 1);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        chk("clr alone acc", acc, 8'h00);
        chk("clr alone valid", out_valid, 0);
        chk("hold y", y, 8'hFF);
        chk("hold par", y_par, 0);

        // Backpressure: 4 beats offered, out_ready low for 3 cycles
        do_reset();
        ir_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        k = 0; ngot = 0;
        acc_mode = 1'b0; op = OP_XOR; b = 8'h10; sel = 8'h00;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
            in_valid  = (k < 4);
            a = 8'(k + 1);
            #1;
            if (c < 8) chk($sformatf("stall in_ready c%0d", c), in_ready, ir_exp[c]);
            if (c == 2 || c == 3) begin
                chk($sformatf("stall y c%0d", c), y, 8'h11);
                chk($sformatf("stall valid c%0d", c), out_valid, 1);
            end
            if (out_valid && out_ready && ngot < 8) begin
                got[ngot] = y;
                ngot++;
            end
            if (in_valid && in_ready) k++;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stall beat count", ngot, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall order %0d", i), got[i], 8'(8'h11 + i));

        // Random vs model at DEPTH 1 and 4
        do_reset();
        acc_m = 8'h00; last1 = 8'h00;
        for (int t = 0; t < 80; t++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a = 8'($urandom); b = 8'($urandom); sel = 8'($urandom);
            op = 2'($urandom_range(0, 3));
            acc_mode = 1'($urandom_range(0, 1));
            acc_clr  = ($urandom_range(0, 7) == 0);
            lft = acc_mode ? (acc_clr ? 8'h00 : acc_m) : a;
            rr  = ref_op(op, lft, b, sel);
            ev[t] = in_valid;
            ey[t] = rr;
            if (in_valid && acc_mode) acc_m = rr;
            else if (acc_clr) acc_m = 8'h00;
            step();
            chk($sformatf("d1 valid t%0d", t), ov1, ev[t]);
            if (ev[t]) begin
                chk($sformatf("d1 y t%0d", t), y1, ey[t]);
                chk($sformatf("d1 zero t%0d", t), z1, (ey[t] == 8'h00));
                chk($sformatf("d1 par t%0d", t), p1, ^ey[t]);
                last1 = ey[t];
            end else begin
                chk($sformatf("d1 hold t%0d", t), y1, last1);
            end
            chk($sformatf("d1 acc t%0d", t), acc1, acc_m);
            chk($sformatf("d4 acc t%0d", t), acc4, acc_m);
            if (t >= 3) begin
                chk($sformatf("d4 valid t%0d", t), ov4, ev[t-3]);
                if (ev[t-3]) begin
                    chk($sformatf("d4 y t%0d", t), y4, ey[t-3]);
                    chk($sformatf("d4 zero t%0d", t), z4, (ey[t-3] == 8'h00));
                    chk($sformatf("d4 par t%0d", t), p4, ^ey[t-3]);
                end
            end else begin
                chk($sformatf("d4 fill t%0d", t), ov4, 0);
            end
        end
        in_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
